// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_t : arbiter FSM state encoding
//   OWN_PIPE / OWN_DBG : owner tag of the access currently in flight
//   STARVE_W / BUSY_CNT_W : widths of the starvation and BUSY-cycle counters
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic OWN_PIPE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;

    localparam int STARVE_W   = 4;
    localparam int BUSY_CNT_W = 8;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of arbitrations the debug port has lost to the pipeline.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   inc        : debug was requesting and the pipeline was granted
//   clr        : debug was granted
//   full       : count has reached STARVE_MAX; debug must win next time
module arb_starve_counter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic full
);

    localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !full) begin
            count <= count + 1'b1;
        end
    end

    assign full = (count == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the pipeline MEM stage
// and a debug/loader port. Pipeline has priority; a starvation guard forces a
// debug grant after STARVE_MAX consecutive lost arbitrations.
// Ports:
//   clk, reset                      : clock, asynchronous active-low reset
//   p_req/p_we/p_addr/p_wdata       : pipeline request (held while p_stall)
//   p_stall, p_rdata                : pipeline freeze, load data (valid in RESP)
//   d_req/d_we/d_addr/d_wdata       : debug request (held until d_ack)
//   d_ack, d_rdata                  : debug completion pulse and load data
//   m_en/m_we/m_addr/m_wdata        : memory command, driven only in BUSY
//   m_rdata, m_ready                : memory read data and completion
//   timeout_err                     : sticky flag, set on a timeout abort
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_stall,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              timeout_err
);

    // Counter value seen on the last BUSY cycle before the abort.
    localparam logic [BUSY_CNT_W-1:0] TO_LAST = BUSY_CNT_W'(TIMEOUT - 1);

    arb_state_t state, state_next;

    logic                  lat_we;
    logic [ADDR_W-1:0]     lat_addr;
    logic [DATA_W-1:0]     lat_wdata;
    logic                  owner;
    logic [BUSY_CNT_W-1:0] busy_cnt;
    logic [DATA_W-1:0]     resp_q;

    logic grant_any;
    logic grant_dbg;
    logic starve_inc;
    logic starve_clr;
    logic starve_full;
    logic busy_done;
    logic busy_timeout;

    arb_starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .full  (starve_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        grant_any    = 1'b0;
        grant_dbg    = 1'b0;
        starve_inc   = 1'b0;
        starve_clr   = 1'b0;
        busy_done    = 1'b0;
        busy_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (p_req || d_req) begin
                    grant_any  = 1'b1;
                    grant_dbg  = d_req && (!p_req || starve_full);
                    starve_clr = grant_dbg;
                    // debug asked but lost to the pipeline
                    starve_inc = d_req && !grant_dbg;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // a completion on the last allowed cycle beats the abort
                if (m_ready) begin
                    busy_done  = 1'b1;
                    state_next = RESP;
                end else if (busy_cnt == TO_LAST) begin
                    busy_timeout = 1'b1;
                    state_next   = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            owner       <= OWN_PIPE;
            busy_cnt    <= '0;
            resp_q      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (grant_any) begin
                lat_we    <= grant_dbg ? d_we    : p_we;
                lat_addr  <= grant_dbg ? d_addr  : p_addr;
                lat_wdata <= grant_dbg ? d_wdata : p_wdata;
                owner     <= grant_dbg ? OWN_DBG : OWN_PIPE;
                busy_cnt  <= '0;
            end else if (state == BUSY) begin
                busy_cnt <= busy_cnt + 1'b1;
            end

            if (busy_done) begin
                resp_q <= lat_we ? '0 : m_rdata;
            end else if (busy_timeout) begin
                resp_q      <= '0;
                timeout_err <= 1'b1;
            end
        end
    end

    assign m_en    = (state == BUSY);
    assign m_we    = (state == BUSY) && lat_we;
    assign m_addr  = (state == BUSY) ? lat_addr  : '0;
    assign m_wdata = (state == BUSY) ? lat_wdata : '0;

    assign p_stall = p_req && !((state == RESP) && (owner == OWN_PIPE));
    assign d_ack   = (state == RESP) && (owner == OWN_DBG);
    assign p_rdata = resp_q;
    assign d_rdata = resp_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (STARVE_MAX=4, TIMEOUT=16).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. A 256-entry memory model answers combinationally.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk;
    logic        reset;
    logic        p_req, p_we;
    logic [63:0] p_addr, p_wdata;
    logic        p_stall;
    logic [63:0] p_rdata;
    logic        d_req, d_we;
    logic [63:0] d_addr, d_wdata;
    logic        d_ack;
    logic [63:0] d_rdata;
    logic        m_en, m_we;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic        m_ready;
    logic        timeout_err;

    logic [63:0] mem [0:255];

    int pass_cnt;
    int check_cnt;

    dmem_arbiter #(
        .ADDR_W     (64),
        .DATA_W     (64),
        .STARVE_MAX (4),
        .TIMEOUT    (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .p_req       (p_req),
        .p_we        (p_we),
        .p_addr      (p_addr),
        .p_wdata     (p_wdata),
        .p_stall     (p_stall),
        .p_rdata     (p_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_ack       (d_ack),
        .d_rdata     (d_rdata),
        .m_en        (m_en),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .m_ready     (m_ready),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign m_rdata = mem[m_addr[7:0]];

    always @(posedge clk) begin
        if (m_en && m_we && m_ready) mem[m_addr[7:0]] <= m_wdata;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        check_cnt++; if (m_en !== 1'b0) $display("FAIL reset_m_en: got %b want 0", m_en); else pass_cnt++;
        check_cnt++; if (d_ack !== 1'b0) $display("FAIL reset_d_ack: got %b want 0", d_ack); else pass_cnt++;
        check_cnt++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b want 0", timeout_err); else pass_cnt++;
        check_cnt++; if (m_addr !== 64'h0 || m_wdata !== 64'h0) $display("FAIL reset_m_bus: got addr %h data %h want 0", m_addr, m_wdata); else pass_cnt++;
        check_cnt++; if (p_rdata !== 64'h0) $display("FAIL reset_rdata: got %h want 0", p_rdata); else pass_cnt++;
        check_cnt++; if (p_stall !== 1'b0) $display("FAIL reset_stall_idle: got %b want 0", p_stall); else pass_cnt++;
        p_req = 1'b1;
        #1;
        check_cnt++; if (p_stall !== 1'b1) $display("FAIL reset_stall_comb: got %b want 1", p_stall); else pass_cnt++;
        p_req = 1'b0;
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic test_pipe_load();
        mem[8'h10] = 64'hABCD;
        p_req = 1'b1; p_we = 1'b0; p_addr = 64'h10;
        @(negedge clk);
        check_cnt++; if (p_stall !== 1'b1 || m_en !== 1'b0) $display("FAIL pload_c0: got stall %b m_en %b want 1 0", p_stall, m_en); else pass_cnt++;
        next_cycle();
        @(negedge clk);
        check_cnt++; if (p_stall !== 1'b1 || m_en !== 1'b1 || m_addr !== 64'h10 || m_we !== 1'b0)
            $display("FAIL pload_c1: got stall %b m_en %b addr %h we %b want 1 1 10 0", p_stall, m_en, m_addr, m_we); else pass_cnt++;
        next_cycle();
        @(negedge clk);
        check_cnt++; if (p_stall !== 1'b0) $display("FAIL pload_c2_stall: got %b want 0", p_stall); else pass_cnt++;
        check_cnt++; if (p_rdata !== 64'hABCD) $display("FAIL pload_rdata: got %h want abcd", p_rdata); else pass_cnt++;
        check_cnt++; if (d_ack !== 1'b0) $display("FAIL pload_no_dack: got %b want 0", d_ack); else pass_cnt++;
        next_cycle();
        p_req = 1'b0;
        @(negedge clk);
        check_cnt++; if (m_en !== 1'b0 || p_stall !== 1'b0) $display("FAIL pload_idle: got m_en %b stall %b want 0 0", m_en, p_stall); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_starvation();
        logic [9:0] exp_dbg;
        logic       prev_dbg_busy;
        int         g;
        exp_dbg = 10'b10000_10000;
        prev_dbg_busy = 1'b0;
        g = 0;
        p_req = 1'b1; p_we = 1'b0; p_addr = 64'h30;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h40;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check_cnt++; if (d_ack !== prev_dbg_busy) $display("FAIL starve_dack_c%0d: got %b want %b", c, d_ack, prev_dbg_busy); else pass_cnt++;
            prev_dbg_busy = 1'b0;
            if (m_en === 1'b1 && g < 10) begin
                check_cnt++; if (m_addr !== (exp_dbg[g] ? 64'h40 : 64'h30))
                    $display("FAIL starve_grant_%0d: got addr %h want %h", g, m_addr, exp_dbg[g] ? 64'h40 : 64'h30); else pass_cnt++;
                prev_dbg_busy = exp_dbg[g];
                g++;
            end
            next_cycle();
        end
        check_cnt++; if (g != 10) $display("FAIL starve_grant_count: got %0d want 10", g); else pass_cnt++;
        p_req = 1'b0; d_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_dbg_write_then_load();
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h20; d_wdata = 64'h55;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check_cnt++; if (m_en !== 1'b1 || m_we !== 1'b1 || m_addr !== 64'h20 || m_wdata !== 64'h55)
            $display("FAIL dwr_cmd: got en %b we %b addr %h data %h want 1 1 20 55", m_en, m_we, m_addr, m_wdata); else pass_cnt++;
        next_cycle();
        @(negedge clk);
        check_cnt++; if (d_ack !== 1'b1) $display("FAIL dwr_ack: got %b want 1", d_ack); else pass_cnt++;
        check_cnt++; if (d_rdata !== 64'h0) $display("FAIL dwr_rdata_zero: got %h want 0", d_rdata); else pass_cnt++;
        next_cycle();
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        check_cnt++; if (d_ack !== 1'b0) $display("FAIL dwr_ack_pulse: got %b want 0", d_ack); else pass_cnt++;
        next_cycle();
        p_req = 1'b1; p_we = 1'b0; p_addr = 64'h20;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_cnt++; if (p_stall !== 1'b0 || p_rdata !== 64'h55) $display("FAIL dwr_pload: got stall %b rdata %h want 0 55", p_stall, p_rdata); else pass_cnt++;
        next_cycle();
        p_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_timeout();
        m_ready = 1'b0;
        p_req = 1'b1; p_we = 1'b0; p_addr = 64'h10;
        for (int b = 1; b <= 16; b++) begin
            next_cycle();
            @(negedge clk);
            check_cnt++; if (m_en !== 1'b1 || p_stall !== 1'b1) $display("FAIL tmo_busy_%0d: got en %b stall %b want 1 1", b, m_en, p_stall); else pass_cnt++;
        end
        next_cycle();
        @(negedge clk);
        check_cnt++; if (m_en !== 1'b0 || p_stall !== 1'b0) $display("FAIL tmo_resp: got en %b stall %b want 0 0", m_en, p_stall); else pass_cnt++;
        check_cnt++; if (p_rdata !== 64'h0) $display("FAIL tmo_rdata: got %h want 0", p_rdata); else pass_cnt++;
        check_cnt++; if (timeout_err !== 1'b1) $display("FAIL tmo_err_set: got %b want 1", timeout_err); else pass_cnt++;
        next_cycle();
        p_req = 1'b0; m_ready = 1'b1;
        d_req = 1'b1; d_addr = 64'h10;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_cnt++; if (d_ack !== 1'b1 || d_rdata !== 64'hABCD) $display("FAIL tmo_after_read: got ack %b rdata %h want 1 abcd", d_ack, d_rdata); else pass_cnt++;
        check_cnt++; if (timeout_err !== 1'b1) $display("FAIL tmo_err_sticky: got %b want 1", timeout_err); else pass_cnt++;
        next_cycle();
        d_req = 1'b0;
        reset = 1'b0;
        #1;
        check_cnt++; if (timeout_err !== 1'b0) $display("FAIL tmo_err_reset: got %b want 0", timeout_err); else pass_cnt++;
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic test_ready_last_cycle();
        mem[8'h18] = 64'h1234;
        m_ready = 1'b0;
        p_req = 1'b1; p_we = 1'b0; p_addr = 64'h18;
        for (int b = 1; b <= 16; b++) begin
            next_cycle();
            if (b == 16) m_ready = 1'b1;
            @(negedge clk);
        end
        check_cnt++; if (m_en !== 1'b1) $display("FAIL late_busy16: got en %b want 1", m_en); else pass_cnt++;
        next_cycle();
        @(negedge clk);
        check_cnt++; if (p_stall !== 1'b0 || p_rdata !== 64'h1234) $display("FAIL late_resp: got stall %b rdata %h want 0 1234", p_stall, p_rdata); else pass_cnt++;
        check_cnt++; if (timeout_err !== 1'b0) $display("FAIL late_no_err: got %b want 0", timeout_err); else pass_cnt++;
        next_cycle();
        p_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid_access();
        m_ready = 1'b0;
        p_req = 1'b1; p_addr = 64'h30;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h40;
        next_cycle();
        @(negedge clk);
        check_cnt++; if (m_en !== 1'b1 || m_addr !== 64'h30) $display("FAIL rmid_busy: got en %b addr %h want 1 30", m_en, m_addr); else pass_cnt++;
        check_cnt++; if (dut.u_starve.count !== 4'd1) $display("FAIL rmid_starve_pre: got %0d want 1", dut.u_starve.count); else pass_cnt++;
        #2;
        reset = 1'b0;
        p_req = 1'b0; d_req = 1'b0;
        #1;
        check_cnt++; if (m_en !== 1'b0 || m_addr !== 64'h0) $display("FAIL rmid_m_en: got en %b addr %h want 0 0", m_en, m_addr); else pass_cnt++;
        check_cnt++; if (dut.state !== IDLE) $display("FAIL rmid_state: got %0d want IDLE", dut.state); else pass_cnt++;
        check_cnt++; if (dut.u_starve.count !== 4'd0) $display("FAIL rmid_starve: got %0d want 0", dut.u_starve.count); else pass_cnt++;
        next_cycle();
        reset = 1'b1;
        d_req = 1'b1; d_addr = 64'h40;
        next_cycle();
        @(negedge clk);
        check_cnt++; if (m_en !== 1'b1 || m_addr !== 64'h40) $display("FAIL rmid_dbg_busy: got en %b addr %h want 1 40", m_en, m_addr); else pass_cnt++;
        #2;
        reset = 1'b0;
        d_req = 1'b0;
        #1;
        check_cnt++; if (m_en !== 1'b0) $display("FAIL rmid_dbg_m_en: got %b want 0", m_en); else pass_cnt++;
        next_cycle();
        reset = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_cnt++; if (d_ack !== 1'b0 || m_en !== 1'b0) $display("FAIL rmid_no_ack_c%0d: got ack %b en %b want 0 0", c, d_ack, m_en); else pass_cnt++;
            next_cycle();
        end
    endtask

    initial begin
        pass_cnt = 0;
        check_cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 64'h0;
        reset = 1'b0;
        p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        m_ready = 1'b1;
        next_cycle();
        test_reset();
        test_pipe_load();
        test_starvation();
        test_dbg_write_then_load();
        test_timeout();
        test_ready_last_cycle();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
